// File: rtl/rom_dl_router.sv
// rom_dl_router: steers ioctl ROM bytes into per-port FIFOs by address window,
// issues them over toggle req/ack SDRAM write ports, captures DIP bytes and
// generates the core reset that is held until the ROM is fully committed.
//
// Ports:
//   clk_sys, reset_n          sole clock, async active-low reset
//   ioctl_download/index/wr/addr/dout   hps_io download stream (inputs)
//   ioctl_wait                backpressure to hps_io
//   soft_reset                OSD/button reset request
//   port_req/port_ack         per-port toggle handshake
//   port_we/port_a/port_ds/port_d       per-port write command
//   dip                       eight captured DIP bytes
//   rom_loaded, core_reset, ovf_err     status
module rom_dl_router #(
  parameter int unsigned          NPORTS      = 2,
  parameter int unsigned          PORT_AW     = 23,
  parameter int unsigned          FIFO_DEPTH  = 4,
  parameter logic [NPORTS*25-1:0] REGION_BASE = {25'h10000, 25'h0},
  parameter logic [NPORTS*25-1:0] REGION_END  = {25'h1FFFF, 25'h1FFFF},
  parameter logic [7:0]           ROM_INDEX   = 8'd0,
  parameter logic [7:0]           DIP_INDEX   = 8'd254,
  parameter logic [15:0]          RST_CYCLES  = 16'hFFFF
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic                      ioctl_download,
  input  logic [7:0]                ioctl_index,
  input  logic                      ioctl_wr,
  input  logic [24:0]               ioctl_addr,
  input  logic [7:0]                ioctl_dout,
  output logic                      ioctl_wait,
  input  logic                      soft_reset,
  output logic [NPORTS-1:0]         port_req,
  input  logic [NPORTS-1:0]         port_ack,
  output logic [NPORTS-1:0]         port_we,
  output logic [NPORTS*PORT_AW-1:0] port_a,
  output logic [NPORTS*2-1:0]       port_ds,
  output logic [NPORTS*16-1:0]      port_d,
  output logic [63:0]               dip,
  output logic                      rom_loaded,
  output logic                      core_reset,
  output logic                      ovf_err
);

  localparam int unsigned OW = PORT_AW + 1;             // {word address, lsb}
  localparam int unsigned EW = OW + 8;                  // FIFO entry width
  localparam int unsigned PW = $clog2(FIFO_DEPTH);      // pointer width
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);  // count 0..FIFO_DEPTH

  logic [EW-1:0] mem   [NPORTS][FIFO_DEPTH];
  logic [PW-1:0] wptr  [NPORTS];
  logic [PW-1:0] rptr  [NPORTS];
  logic [CW-1:0] cnt   [NPORTS];
  logic [OW-1:0] off_c [NPORTS];
  logic [EW-1:0] entry_c [NPORTS];
  logic [EW-1:0] head_c  [NPORTS];

  logic [NPORTS-1:0] hit_c, push_c, pop_c, drop_c, idle_c;
  logic              rom_wr_c, dip_wr_c, wait_c, drained_c, reload_c;
  logic              all_idle_c, all_empty_c;
  logic              dl_d, rom_pending;
  logic [15:0]       rst_cnt;

  // Address decode, FIFO push/pop decisions and drain status.
  always_comb begin
    rom_wr_c    = ioctl_wr && ioctl_download && (ioctl_index == ROM_INDEX);
    dip_wr_c    = ioctl_wr && (ioctl_index == DIP_INDEX) && (ioctl_addr[24:3] == 22'd0);
    wait_c      = 1'b0;
    all_idle_c  = 1'b1;
    all_empty_c = 1'b1;
    hit_c       = '0;
    push_c      = '0;
    pop_c       = '0;
    drop_c      = '0;
    idle_c      = '0;
    for (int i = 0; i < NPORTS; i++) begin
      off_c[i]   = OW'(ioctl_addr - REGION_BASE[i*25 +: 25]);
      entry_c[i] = {off_c[i], ioctl_dout};
      head_c[i]  = mem[i][rptr[i]];
      hit_c[i]   = rom_wr_c && (ioctl_addr >= REGION_BASE[i*25 +: 25])
                            && (ioctl_addr <= REGION_END[i*25 +: 25]);
      idle_c[i]  = (port_req[i] == port_ack[i]);
      push_c[i]  = hit_c[i] && (cnt[i] != CW'(FIFO_DEPTH));
      drop_c[i]  = hit_c[i] && (cnt[i] == CW'(FIFO_DEPTH));
      pop_c[i]   = idle_c[i] && (cnt[i] != CW'(0));
      if (cnt[i] >= CW'(FIFO_DEPTH - 1)) wait_c = 1'b1;
      if (cnt[i] != CW'(0))              all_empty_c = 1'b0;
      if (!idle_c[i])                    all_idle_c = 1'b0;
    end
    drained_c = rom_pending && all_empty_c && all_idle_c;
    reload_c  = soft_reset || ioctl_download || !rom_loaded;
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk_sys) begin
    for (int i = 0; i < NPORTS; i++) begin
      if (push_c[i]) mem[i][wptr[i]] <= entry_c[i];
    end
  end

  // FIFO pointers/counts and port issue.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      port_req <= '0;
      port_a   <= '0;
      port_ds  <= '0;
      port_d   <= '0;
      for (int i = 0; i < NPORTS; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        if (push_c[i]) wptr[i] <= wptr[i] + PW'(1);
        if (pop_c[i]) begin
          rptr[i]                    <= rptr[i] + PW'(1);
          port_a[i*PORT_AW +: PORT_AW] <= head_c[i][EW-1:9];
          port_ds[i*2 +: 2]          <= {head_c[i][8], ~head_c[i][8]};
          port_d[i*16 +: 16]         <= {head_c[i][7:0], head_c[i][7:0]};
          port_req[i]                <= ~port_req[i];
        end
        if (push_c[i] && !pop_c[i])      cnt[i] <= cnt[i] + CW'(1);
        else if (!push_c[i] && pop_c[i]) cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end

  // Status, DIP capture and ROM commit tracking.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      port_we     <= '0;
      ioctl_wait  <= 1'b0;
      ovf_err     <= 1'b0;
      dip         <= '0;
      dl_d        <= 1'b0;
      rom_pending <= 1'b0;
      rom_loaded  <= 1'b0;
    end else begin
      port_we    <= {NPORTS{ioctl_download}};
      ioctl_wait <= wait_c;
      dl_d       <= ioctl_download;
      if (|drop_c) ovf_err <= 1'b1;
      if (dip_wr_c) dip[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
      // Only the end of a ROM download arms the commit; DIP downloads do not.
      if (dl_d && !ioctl_download && (ioctl_index == ROM_INDEX)) rom_pending <= 1'b1;
      if (drained_c) rom_loaded <= 1'b1;
    end
  end

  // Reset stretcher; the reload cycle itself counts as reset so a single-cycle
  // request produces RST_CYCLES+1 cycles of core_reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rst_cnt    <= RST_CYCLES;
      core_reset <= 1'b1;
    end else begin
      core_reset <= reload_c || (rst_cnt != 16'd0);
      if (reload_c)               rst_cnt <= RST_CYCLES;
      else if (rst_cnt != 16'd0)  rst_cnt <= rst_cnt - 16'd1;
    end
  end

endmodule

// File: tb/tb_rom_dl_router.sv
// Directed bench for rom_dl_router with default windows and RST_CYCLES=16.
module tb_rom_dl_router;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        soft_reset;
  logic [1:0]  port_req;
  logic [1:0]  port_ack;
  logic [1:0]  port_we;
  logic [45:0] port_a;
  logic [3:0]  port_ds;
  logic [31:0] port_d;
  logic [63:0] dip;
  logic        rom_loaded;
  logic        core_reset;
  logic        ovf_err;

  logic ack0 = 1'b0;
  logic ack1 = 1'b0;
  bit   auto_ack0 = 1'b0;
  int   checks = 0;
  int   errors = 0;

  assign port_ack = {ack1, ack0};

  always #5 clk_sys = ~clk_sys;

  // Port 0 responder: acknowledges every request half a cycle later.
  always @(negedge clk_sys) if (auto_ack0) ack0 = port_req[0];

  rom_dl_router #(.RST_CYCLES(16'd16)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .soft_reset(soft_reset),
    .port_req(port_req), .port_ack(port_ack), .port_we(port_we),
    .port_a(port_a), .port_ds(port_ds), .port_d(port_d),
    .dip(dip), .rom_loaded(rom_loaded), .core_reset(core_reset), .ovf_err(ovf_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [24:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr   = 1'b0;
  endtask

  // Wait (bounded) for port_req[p] to move away from prev.
  task automatic wait_req(input int p, input logic prev, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_sys);
      if (port_req[p] !== prev) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Acknowledge port 1 and wait for its next issue.
  task automatic ack_and_issue1(input string tag);
    bit   ok;
    logic prev;
    prev = port_req[1];
    ack1 = port_req[1];
    wait_req(1, prev, ok);
    check(tag, 64'(ok), 64'd1);
  endtask

  // Count consecutive negedges with core_reset high, starting now.
  task automatic count_high(output int n);
    n = 0;
    while (core_reset === 1'b1 && n < 40) begin
      n++;
      @(negedge clk_sys);
    end
  endtask

  initial begin
    int          n;
    logic [1:0]  req_save;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; soft_reset = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    check("rst_core_reset", 64'(core_reset), 64'd1);
    check("rst_port_req",   64'(port_req), 64'd0);
    check("rst_dip",        dip, 64'd0);
    check("rst_rom_loaded", 64'(rom_loaded), 64'd0);
    check("rst_ovf_wait",   64'({ovf_err, ioctl_wait, port_we}), 64'd0);
    check("rst_port_a",     64'(port_a), 64'd0);

    // Two-port routing of one byte in the overlap window.
    ioctl_download = 1'b1;
    strobe(25'h10003, 8'hA5);
    check("route_req_t1", 64'(port_req), 64'd0);
    @(negedge clk_sys);
    check("route_req_t2", 64'(port_req), 64'b11);
    check("route_a0",  64'(port_a[22:0]), 64'h8001);
    check("route_a1",  64'(port_a[45:23]), 64'h1);
    check("route_ds",  64'(port_ds), 64'b1010);
    check("route_d",   64'(port_d), 64'hA5A5A5A5);
    check("route_we",  64'(port_we), 64'b11);

    // Port-0-only address; port 1 window does not cover it.
    auto_ack0 = 1'b1;
    strobe(25'h00004, 8'h99);
    @(negedge clk_sys);
    check("p0_only_a0",  64'(port_a[22:0]), 64'h2);
    check("p0_only_ds0", 64'(port_ds[1:0]), 64'b01);
    check("p0_only_d0",  64'(port_d[15:0]), 64'h9999);
    check("p0_only_req1", 64'(port_req[1]), 64'd1);

    // Backpressure: port 1 stays busy, its FIFO fills.
    strobe(25'h10010, 8'h11);
    strobe(25'h10011, 8'h22);
    check("bp_wait_2", 64'(ioctl_wait), 64'd0);
    strobe(25'h10012, 8'h33);
    check("bp_wait_3", 64'(ioctl_wait), 64'd0);
    strobe(25'h10013, 8'h44);
    check("bp_wait_on", 64'(ioctl_wait), 64'd1);
    check("bp_no_ovf", 64'(ovf_err), 64'd0);
    strobe(25'h10014, 8'h55);
    check("bp_ovf", 64'(ovf_err), 64'd1);

    // Drain in order.
    ack_and_issue1("drain0_issue");
    check("drain0", 64'({port_a[45:23], port_ds[3:2], port_d[31:16]}), 64'({23'h8, 2'b01, 16'h1111}));
    ack_and_issue1("drain1_issue");
    check("drain1", 64'({port_a[45:23], port_ds[3:2], port_d[31:16]}), 64'({23'h8, 2'b10, 16'h2222}));
    ack_and_issue1("drain2_issue");
    check("drain2", 64'({port_a[45:23], port_ds[3:2], port_d[31:16]}), 64'({23'h9, 2'b01, 16'h3333}));
    ack_and_issue1("drain3_issue");
    check("drain3", 64'({port_a[45:23], port_ds[3:2], port_d[31:16]}), 64'({23'h9, 2'b10, 16'h4444}));
    @(negedge clk_sys);
    check("drain_wait_off", 64'(ioctl_wait), 64'd0);
    check("drain_ovf_sticky", 64'(ovf_err), 64'd1);

    // Load completion with two entries still queued.
    strobe(25'h10020, 8'h66);
    strobe(25'h10021, 8'h77);
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("load_pending", 64'(rom_loaded), 64'd0);
    check("load_we_off", 64'(port_we), 64'd0);
    ack_and_issue1("load_issue0");
    check("load_e0", 64'({port_a[45:23], port_ds[3:2], port_d[31:16]}), 64'({23'h10, 2'b01, 16'h6666}));
    check("load_still0_a", 64'(rom_loaded), 64'd0);
    ack_and_issue1("load_issue1");
    check("load_e1", 64'({port_a[45:23], port_ds[3:2], port_d[31:16]}), 64'({23'h10, 2'b10, 16'h7777}));
    check("load_still0_b", 64'(rom_loaded), 64'd0);
    ack1 = port_req[1];
    @(negedge clk_sys);
    check("load_done", 64'(rom_loaded), 64'd1);
    count_high(n);
    check("load_core_reset_len", 64'(n), 64'd17);

    // DIP capture.
    ioctl_index = 8'd254;
    ioctl_download = 1'b1;
    req_save = port_req;
    strobe(25'h2, 8'h3C);
    check("dip_byte2", dip, 64'h0000_0000_003C_0000);
    strobe(25'h8, 8'hFF);
    check("dip_addr8_ignored", dip, 64'h0000_0000_003C_0000);
    strobe(25'h7, 8'h5A);
    check("dip_byte7", dip, 64'h5A00_0000_003C_0000);
    repeat (3) @(negedge clk_sys);
    check("dip_no_req", 64'(port_req), 64'(req_save));
    ioctl_download = 1'b0;
    repeat (25) @(negedge clk_sys);
    check("dip_core_reset_off", 64'(core_reset), 64'd0);
    check("dip_rom_loaded", 64'(rom_loaded), 64'd1);

    // Soft reset after boot.
    @(negedge clk_sys);
    soft_reset = 1'b1;
    @(negedge clk_sys);
    soft_reset = 1'b0;
    count_high(n);
    check("soft_core_reset_len", 64'(n), 64'd17);
    check("soft_rom_loaded", 64'(rom_loaded), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
